// File: rtl/meter_pkg.sv
// Shared types and defaults for the square-wave period/high-time meter.
package meter_pkg;

  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } meter_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Optional input synchroniser followed by an edge register; emits one-cycle rise/fall pulses.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic s;
  logic s_ok;
  logic prev_q, prev_d;
  logic arm_q, arm_d;

  if (SYNC_STAGES == 0) begin : g_direct
    assign s    = sig_in;
    assign s_ok = 1'b1;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] vld_q, vld_d;

    always_comb begin
      sync_d    = sync_q;
      vld_d     = vld_q;
      sync_d[0] = sig_in;
      vld_d[0]  = 1'b1;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_d[k] = sync_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
    end

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        sync_q <= '0;
        vld_q  <= '0;
      end else begin
        sync_q <= sync_d;
        vld_q  <= vld_d;
      end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign s_ok = vld_q[SYNC_STAGES-1];
  end

  // Edges are armed only after a genuine low has been seen, so a level that is
  // already high when reset releases never counts as a rise.
  always_comb begin
    prev_d = s;
    arm_d  = arm_q | (s_ok & ~s);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end

  assign rise = arm_q & s & ~prev_q;
  assign fall = arm_q & ~s & prev_q;

endmodule

// File: rtl/square_wave_meter.sv
// Measures period and high time of a square wave in clock cycles, with a
// one-cycle meas_valid strobe per period and a timeout on loss of activity.
module square_wave_meter
  import meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             locked,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic rise, fall;

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             mv_q, mv_d;
  logic             to_q, to_d;
  logic             locked_q, locked_d;
  logic             sat;
  logic             expire;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clock  (clock),
    .reset_n(reset_n),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  assign sat = (cnt_q == CNT_MAX);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    mv_d     = 1'b0;
    to_d     = 1'b0;
    locked_d = locked_q;
    expire   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (sat) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (fall) begin
            hcnt_d  = cnt_q;
            state_d = LOW;
          end
        end
      end
      LOW: begin
        // A rise on the saturating cycle still completes a valid period.
        if (rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          mv_d     = 1'b1;
          locked_d = 1'b1;
          cnt_d    = CNT_ONE;
          state_d  = HIGH;
        end else if (sat) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (expire) begin
      to_d     = 1'b1;
      locked_d = 1'b0;
      cnt_d    = '0;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      to_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      to_q     <= to_d;
      locked_q <= locked_d;
    end
  end

  // meas_valid and timeout are single-cycle strobes; period/high_time are
  // stable except in a meas_valid cycle.
  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = mv_q;
  assign timeout    = to_q;
  assign locked     = locked_q;
  assign dbg_state  = state_q;

endmodule
